pooling_layer_controller: RTL and testbench

//  Sequences the pooling stage: accepts KERNEL_SIZE-word column slices from the conv stage, fires the input-buffer load strobe
//  (kernel_calc_fin), and times the serial shift-out of buffer[0] into the max comparator. Generates comparator clear/enable,

---
 rtl/pooling_pkg.sv | 14 +
 rtl/pooling_layer_controller_if.sv | 29 ++
 rtl/pooling_window_counter.sv | 53 +++++
 rtl/pooling_layer_controller.sv | 82 ++++++++
 tb/tb_pooling_layer_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pooling_pkg.sv
// Shared types and sizing helpers for the pooling-stage controller.
package pooling_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_COL, SHIFT, DONE} state_t;

    localparam int KERNEL_SIZE_DEF = 2;
    localparam int INPUT_SIZE_DEF  = 6;

    // Width of a counter/address covering 0..n-1, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pooling_layer_controller_if.sv
// Handshake, comparator-strobe and status bundle between the controller and its neighbours.
interface pooling_layer_controller_if
    import pooling_pkg::*;
#(
    parameter int ADDR_W = addr_w((INPUT_SIZE_DEF / KERNEL_SIZE_DEF) * (INPUT_SIZE_DEF / KERNEL_SIZE_DEF))
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              kernel_calc_fin;
    logic              max_clear;
    logic              max_en;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, in_valid,
        input  in_ready, kernel_calc_fin, max_clear, max_en,
               out_valid, out_addr, busy, frame_done
    );

    modport slave (
        input  start, in_valid,
        output in_ready, kernel_calc_fin, max_clear, max_en,
               out_valid, out_addr, busy, frame_done
    );
endinterface

// File: rtl/pooling_window_counter.sv
// Element / column / band position counters for one pooling frame, with wrap flags.
module pooling_window_counter
    import pooling_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
    parameter int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE,
    parameter int EW          = addr_w(KERNEL_SIZE),
    parameter int CW          = addr_w(INPUT_SIZE),
    parameter int BW          = addr_w(OUTPUT_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    output logic [EW-1:0] elem,
    output logic [CW-1:0] col,
    output logic [BW-1:0] band,
    output logic          last_elem,
    output logic          last_frame
);
    logic last_col;
    logic last_band;

    assign last_elem  = (elem == EW'(KERNEL_SIZE - 1));
    assign last_col   = (col  == CW'(INPUT_SIZE - 1));
    assign last_band  = (band == BW'(OUTPUT_SIZE - 1));
    assign last_frame = last_col && last_band;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem <= '0;
            col  <= '0;
            band <= '0;
        end else if (clr) begin
            elem <= '0;
            col  <= '0;
            band <= '0;
        end else if (step) begin
            if (last_elem) begin
                elem <= '0;
                if (last_col) begin
                    col  <= '0;
                    band <= last_band ? '0 : band + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                elem <= elem + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pooling_layer_controller.sv
// Pooling-stage sequencer: accepts column slices, shifts buffer[0] into the max comparator, emits pooled-result valid/address.
module pooling_layer_controller
    import pooling_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int INPUT_SIZE  = INPUT_SIZE_DEF
) (
    input logic                        clk,
    input logic                        rst_n,
    pooling_layer_controller_if.slave  bus
);
    localparam int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE;
    localparam int ADDR_W      = addr_w(OUTPUT_SIZE * OUTPUT_SIZE);
    localparam int EW          = addr_w(KERNEL_SIZE);
    localparam int CW          = addr_w(INPUT_SIZE);
    localparam int BW          = addr_w(OUTPUT_SIZE);

    state_t            state;
    logic [EW-1:0]     elem;
    logic [CW-1:0]     col;
    logic [BW-1:0]     band;
    logic              last_elem;
    logic              last_frame;
    logic              shifting;
    logic              in_ready;
    logic              win_end;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;

    pooling_window_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .INPUT_SIZE  (INPUT_SIZE)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state == IDLE),
        .step       (shifting),
        .elem       (elem),
        .col        (col),
        .band       (band),
        .last_elem  (last_elem),
        .last_frame (last_frame)
    );

    assign shifting = (state == SHIFT);
    // The next slice may load on the final shift cycle; the load overwrites the buffer as its last word is consumed.
    assign in_ready = (state == WAIT_COL) || (shifting && last_elem && !last_frame);
    assign win_end  = shifting && last_elem && ((int'(col) % KERNEL_SIZE) == KERNEL_SIZE - 1);

    assign bus.in_ready        = in_ready;
    assign bus.kernel_calc_fin = bus.in_valid & in_ready;
    assign bus.max_en          = shifting;
    assign bus.max_clear       = shifting && (elem == '0) && ((int'(col) % KERNEL_SIZE) == 0);
    assign bus.out_valid       = out_valid;
    assign bus.out_addr        = out_addr;
    assign bus.busy            = (state != IDLE);
    assign bus.frame_done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_addr  <= '0;
        end else begin
            out_valid <= win_end;
            if (win_end)
                out_addr <= ADDR_W'(int'(band) * OUTPUT_SIZE + int'(col) / KERNEL_SIZE);
            case (state)
                IDLE:     if (bus.start) state <= WAIT_COL;
                WAIT_COL: if (bus.in_valid) state <= SHIFT;
                SHIFT: begin
                    if (last_elem) begin
                        if (last_frame)         state <= DONE;
                        else if (!bus.in_valid) state <= WAIT_COL;
                    end
                end
                DONE:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pooling_layer_controller.sv
// Directed bench for the pooling controller with a behavioural buffer/max-comparator driven by its strobes.
module tb_pooling_layer_controller;
    import pooling_pkg::*;

    localparam int K  = 2;
    localparam int N  = 6;
    localparam int OS = 3;
    localparam int AW = 4;
    localparam int NONE = 999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pooling_layer_controller_if #(.ADDR_W(AW)) bus();

    pooling_layer_controller #(
        .KERNEL_SIZE (K),
        .INPUT_SIZE  (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Datapath model: ramp frame 0..35 row-major, slice n = column n%N of band n/N.
    int buf_m [K];
    int acc;
    int load_idx;
    bit model_clr = 1'b0;

    always @(posedge clk) begin
        if (model_clr) load_idx <= 0;
        else if (bus.kernel_calc_fin) load_idx <= load_idx + 1;
        if (bus.kernel_calc_fin) begin
            for (int r = 0; r < K; r++)
                buf_m[r] <= ((load_idx / N) * K + r) * N + (load_idx % N);
        end else if (bus.max_en) begin
            for (int r = 0; r < K - 1; r++)
                buf_m[r] <= buf_m[r + 1];
        end
        if (bus.max_en)
            acc <= (bus.max_clear || buf_m[0] > acc) ? buf_m[0] : acc;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int n_load, sum_load, first_load, last_load;
    int n_en, first_en, last_en;
    int n_clr, sum_clr;
    int n_done, done_cyc;
    int en_win, rdy_win, rst_nonzero, post_rst_outs;
    int oa_q[$];
    int ov_q[$];
    int oc_q[$];
    bit busy_at [0:127];

    function automatic bit any_out();
        return |{bus.in_ready, bus.kernel_calc_fin, bus.max_clear, bus.max_en,
                 bus.out_valid, bus.out_addr, bus.busy, bus.frame_done};
    endfunction

    task automatic run(input int ncyc, input int drop_lo, input int drop_hi,
                       input int restart_at, input int rst_at, input int wlo, input int whi);
        n_load = 0; sum_load = 0; first_load = -1; last_load = -1;
        n_en = 0; first_en = -1; last_en = -1;
        n_clr = 0; sum_clr = 0; n_done = 0; done_cyc = -1;
        en_win = 0; rdy_win = 0; rst_nonzero = 0; post_rst_outs = 0;
        oa_q.delete(); ov_q.delete(); oc_q.delete();
        for (int i = 0; i < 128; i++) busy_at[i] = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start    = (c == 0) || (c == restart_at);
            bus.in_valid = !(c >= drop_lo && c <= drop_hi);
            rst_n        = !(c == rst_at || c == rst_at + 1);
            model_clr    = (c == 0);
            @(negedge clk);
            if (bus.kernel_calc_fin) begin
                n_load++; sum_load += c; last_load = c;
                if (first_load < 0) first_load = c;
            end
            if (bus.max_en) begin
                n_en++; last_en = c;
                if (first_en < 0) first_en = c;
            end
            if (bus.max_clear) begin n_clr++; sum_clr += c; end
            if (bus.out_valid) begin
                oa_q.push_back(int'(bus.out_addr));
                ov_q.push_back(acc);
                oc_q.push_back(c);
                if (c >= rst_at) post_rst_outs++;
            end
            if (bus.frame_done) begin n_done++; done_cyc = c; end
            busy_at[c] = bus.busy;
            if (c >= wlo && c <= whi) begin
                en_win  += int'(bus.max_en);
                rdy_win += int'(bus.in_ready);
            end
            if (!rst_n && any_out()) rst_nonzero++;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        model_clr = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_done, input bit exact);
        chk({tag, " loads"}, n_load, 18);
        chk({tag, " first_load"}, first_load, 1);
        chk({tag, " max_en_cnt"}, n_en, 36);
        chk({tag, " first_en"}, first_en, 2);
        chk({tag, " clears"}, n_clr, 9);
        chk({tag, " done_cnt"}, n_done, 1);
        chk({tag, " done_cyc"}, done_cyc, exp_done);
        chk({tag, " busy_start"}, int'(busy_at[1]), 1);
        chk({tag, " busy_last"}, int'(busy_at[exp_done]), 1);
        chk({tag, " busy_drop"}, int'(busy_at[exp_done + 1]), 0);
        chk({tag, " outs"}, oa_q.size(), OS * OS);
        if (oa_q.size() == OS * OS) begin
            chk({tag, " first_out"}, oc_q[0], 6);
            chk({tag, " last_out"}, oc_q[OS * OS - 1], exp_done);
            for (int a = 0; a < OS * OS; a++) begin
                chk($sformatf("%s addr%0d", tag, a), oa_q[a], a);
                chk($sformatf("%s val%0d", tag, a), ov_q[a], (2 * (a / OS) + 1) * N + 2 * (a % OS) + 1);
            end
        end
        if (exact) begin
            chk({tag, " load_sum"}, sum_load, 324);
            chk({tag, " last_load"}, last_load, 35);
            chk({tag, " last_en"}, last_en, 37);
            chk({tag, " clr_sum"}, sum_clr, 162);
            for (int i = 0; i < OS * OS; i++)
                chk($sformatf("%s out_cyc%0d", tag, i), oc_q.size() > i ? oc_q[i] : -1, 6 + 4 * i);
        end
    endtask

    initial begin
        int idle_hits;
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", int'(any_out()), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // in_valid without start must never be accepted.
        idle_hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.in_ready || bus.kernel_calc_fin || bus.busy) idle_hits++;
        end
        chk("idle accept", idle_hits, 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        run(45, NONE, NONE, NONE, NONE, NONE, NONE);
        check_frame("b2b", 38, 1'b1);

        run(50, 4, 9, NONE, NONE, 6, 9);
        chk("gap max_en", en_win, 0);
        chk("gap in_ready", rdy_win, 4);
        check_frame("gap", 43, 1'b0);

        run(45, NONE, NONE, 10, NONE, NONE, NONE);
        check_frame("restart", 38, 1'b1);

        run(45, NONE, NONE, NONE, 15, NONE, NONE);
        chk("rst outputs", rst_nonzero, 0);
        chk("rst post outs", post_rst_outs, 0);
        chk("rst pre outs", oa_q.size(), 3);
        chk("rst done", n_done, 0);
        chk("rst busy", int'(busy_at[20]), 0);

        run(45, NONE, NONE, NONE, NONE, NONE, NONE);
        check_frame("after_rst", 38, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
